// File: rtl/preg_release_queue_pkg.sv
// Shared rename types for the preg release queue.
//   PREG_ID_W     : default physical register ID width
//   preg_id_t     : physical register ID
//   PREG_ZERO     : hard-wired zero register ID, never returned to the free list
//   drain_state_e : drain handshake states
package preg_release_queue_pkg;

  localparam int PREG_ID_W = 7;

  typedef logic [PREG_ID_W-1:0] preg_id_t;

  localparam preg_id_t PREG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/preg_release_queue_if.sv
// Bundle between ROB commit / free list / flush logic and the release queue.
//   release side : rel_valid_1/2, rel_preg_1/2 in, rel_ready out
//   free list    : fl_push, fl_push_data, fl_push_2, fl_push_data_2 out, fl_ready in
//   drain        : drain_req in, drain_ack out
//   status       : occupancy out
// master = the surroundings driving the queue, slave = the queue itself.
interface preg_release_queue_if #(
  parameter int PREG_W = 7,
  parameter int DEPTH  = 8
);

  logic                     rel_valid_1;
  logic [PREG_W-1:0]        rel_preg_1;
  logic                     rel_valid_2;
  logic [PREG_W-1:0]        rel_preg_2;
  logic                     rel_ready;
  logic                     fl_push;
  logic [PREG_W-1:0]        fl_push_data;
  logic                     fl_push_2;
  logic [PREG_W-1:0]        fl_push_data_2;
  logic                     fl_ready;
  logic                     drain_req;
  logic                     drain_ack;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output rel_valid_1, rel_preg_1, rel_valid_2, rel_preg_2, fl_ready, drain_req,
    input  rel_ready, fl_push, fl_push_data, fl_push_2, fl_push_data_2, drain_ack, occupancy
  );

  modport slave (
    input  rel_valid_1, rel_preg_1, rel_valid_2, rel_preg_2, fl_ready, drain_req,
    output rel_ready, fl_push, fl_push_data, fl_push_2, fl_push_data_2, drain_ack, occupancy
  );

endinterface

// File: rtl/preg_release_queue.sv
// Release queue between ROB commit and the rename free list.
// Accepts up to two released preg IDs per cycle, drops the zero register,
// stores kept IDs compacted in a circular buffer and drains up to two per
// cycle into the free list's dual push channel. A drain handshake lets
// recovery logic wait until every pending release has reached the free list.
//   clk, rst_n : clock, async active-low reset
//   q (slave)  : release, free-list push, drain and occupancy signals
//
// state | meaning
// IDLE  | normal operation, releases accepted
// DRAIN | releases blocked, emptying the queue
// DONE  | queue empty, drain_ack held until drain_req drops
module preg_release_queue
  import preg_release_queue_pkg::*;
#(
  parameter int PREG_W    = PREG_ID_W,
  parameter int DEPTH     = 8,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  preg_release_queue_if.slave  q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     wr_addr_2, rd_addr_2;
  logic [CW-1:0]     count_q, count_d;
  drain_state_e      state_q, state_d;
  logic              rel_ready, keep_1, keep_2, drain_ack;
  logic [1:0]        enq, deq;

  // Two free slots are required even for a single release so the ready
  // never depends on how many slots commit presents.
  assign rel_ready = ((DEPTH_C - count_q) >= CW'(2)) && (state_q == IDLE);

  assign keep_1 = q.rel_valid_1 && rel_ready &&
                  !(DROP_ZERO && (q.rel_preg_1 == PREG_W'(PREG_ZERO)));
  assign keep_2 = q.rel_valid_2 && rel_ready &&
                  !(DROP_ZERO && (q.rel_preg_2 == PREG_W'(PREG_ZERO)));

  assign enq       = {1'b0, keep_1} + {1'b0, keep_2};
  // A lone kept slot-2 ID lands at wr_ptr, otherwise right after slot 1.
  assign wr_addr_2 = wr_ptr_q + AW'(keep_1);
  assign rd_addr_2 = rd_ptr_q + AW'(1);

  always_comb begin
    deq = 2'd0;
    if (q.fl_ready) begin
      deq = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    end
  end

  assign count_d  = count_q + CW'(enq) - CW'(deq);
  assign wr_ptr_d = wr_ptr_q + AW'(enq);
  assign rd_ptr_d = rd_ptr_q + AW'(deq);

  // Storage is not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (keep_1) mem_q[wr_ptr_q]  <= q.rel_preg_1;
    if (keep_2) mem_q[wr_addr_2] <= q.rel_preg_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (q.drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        // An abandoned request returns to IDLE without acknowledging.
        if (!q.drain_req)          state_d = IDLE;
        else if (count_d == '0)    state_d = DONE;
      end
      DONE: begin
        drain_ack = 1'b1;
        if (!q.drain_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign q.rel_ready      = rel_ready;
  assign q.fl_push        = (deq != 2'd0);
  assign q.fl_push_2      = (deq == 2'd2);
  assign q.fl_push_data   = mem_q[rd_ptr_q];
  assign q.fl_push_data_2 = mem_q[rd_addr_2];
  assign q.drain_ack      = drain_ack;
  assign q.occupancy      = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);

endmodule

// File: tb/tb_preg_release_queue.sv
module tb_preg_release_queue;
  import preg_release_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  preg_release_queue_if #(.PREG_W(PREG_ID_W), .DEPTH(DEPTH)) bus();

  preg_release_queue #(
    .PREG_W   (PREG_ID_W),
    .DEPTH    (DEPTH),
    .DROP_ZERO(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (bus)
  );

  int checks = 0;
  int errors = 0;

  preg_id_t     sb[$];
  int           m_count;
  drain_state_e m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_state = IDLE;
    sb.delete();
  endtask

  // One clock cycle: drive inputs just after a rising edge, check outputs
  // against the reference model, update the model, advance past the edge.
  task automatic cyc(input bit v1, input int p1, input bit v2, input int p2,
                     input bit flr, input bit dreq);
    bit       m_ready;
    int       deq;
    int       enq;
    int       nxt;
    preg_id_t e;
    bus.rel_valid_1 = v1;
    bus.rel_preg_1  = preg_id_t'(p1);
    bus.rel_valid_2 = v2;
    bus.rel_preg_2  = preg_id_t'(p2);
    bus.fl_ready    = flr;
    bus.drain_req   = dreq;
    #1;
    m_ready = ((DEPTH - m_count) >= 2) && (m_state == IDLE);
    deq     = flr ? ((m_count >= 2) ? 2 : m_count) : 0;
    chk("rel_ready", bus.rel_ready, m_ready);
    chk("occupancy", bus.occupancy, m_count);
    chk("drain_ack", bus.drain_ack, m_state == DONE);
    chk("fl_push", bus.fl_push, deq >= 1);
    chk("fl_push_2", bus.fl_push_2, deq == 2);
    if (deq >= 1) begin
      e = sb.pop_front();
      chk("fl_push_data", bus.fl_push_data, e);
    end
    if (deq == 2) begin
      e = sb.pop_front();
      chk("fl_push_data_2", bus.fl_push_data_2, e);
    end
    enq = 0;
    if (m_ready && v1 && p1 != 0) begin sb.push_back(preg_id_t'(p1)); enq++; end
    if (m_ready && v2 && p2 != 0) begin sb.push_back(preg_id_t'(p2)); enq++; end
    nxt = m_count + enq - deq;
    case (m_state)
      IDLE:    if (dreq) m_state = DRAIN;
      DRAIN:   if (!dreq) m_state = IDLE; else if (nxt == 0) m_state = DONE;
      DONE:    if (!dreq) m_state = IDLE;
      default: m_state = IDLE;
    endcase
    m_count = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.rel_valid_1 = 1'b0;
    bus.rel_preg_1  = '0;
    bus.rel_valid_2 = 1'b0;
    bus.rel_preg_2  = '0;
    bus.fl_ready    = 1'b1;
    bus.drain_req   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rel_ready", bus.rel_ready, 1'b1);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_fl_push", bus.fl_push, 1'b0);
    chk("rst_fl_push_2", bus.fl_push_2, 1'b0);
    chk("rst_drain_ack", bus.drain_ack, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic flush_queue();
    for (int i = 0; i < 2 * DEPTH && m_count > 0; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("flush_empty", m_count, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // basic dual release
    cyc(1, 'h25, 1, 'h26, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // zero filter and compaction
    cyc(1, 'h00, 1, 'h30, 1, 0);
    cyc(1, 'h00, 0, 0, 1, 0);
    cyc(0, 0, 1, 'h31, 1, 0);
    cyc(1, 'h32, 1, 'h00, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    flush_queue();

    // backpressure up to full, then 2-wide drain in order
    cyc(1, 'h01, 1, 'h02, 0, 0);
    cyc(1, 'h03, 1, 'h04, 0, 0);
    cyc(1, 'h05, 1, 'h06, 0, 0);
    cyc(1, 'h07, 1, 'h08, 0, 0);
    cyc(1, 'h09, 1, 'h0a, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("bp_empty", sb.size(), 0);

    // wrap-around: preload 7, drain 6, enqueue 4 across index 7/0
    do_reset();
    cyc(1, 'h11, 1, 'h12, 0, 0);
    cyc(1, 'h13, 1, 'h14, 0, 0);
    cyc(1, 'h15, 1, 'h16, 0, 0);
    cyc(1, 'h17, 0, 0, 0, 0);
    cyc(1, 'h18, 1, 'h19, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 'h21, 1, 'h22, 0, 0);
    cyc(0, 0, 1, 'h23, 0, 0);
    cyc(1, 'h24, 0, 0, 0, 0);
    flush_queue();

    // random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      int p1, p2;
      p1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      p2 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      cyc(1'($urandom_range(0, 1)), p1, 1'($urandom_range(0, 1)), p2,
          1'($urandom_range(0, 2) != 0), 0);
    end
    flush_queue();

    // drain with occupancy 5: pushes 2,2,1 then ack held until req drops
    cyc(1, 'h41, 1, 'h42, 0, 0);
    cyc(1, 'h43, 1, 'h44, 0, 0);
    cyc(1, 'h45, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 'h46, 1, 'h47, 1, 1);
    cyc(1, 'h48, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // drain on an empty queue: ack two cycles after the request
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);

    // drain abandoned mid-way: back to IDLE, no ack
    cyc(1, 'h51, 1, 'h52, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 'h53, 0, 0, 0, 0);
    flush_queue();

    // async reset between edges with occupancy 4
    cyc(1, 'h61, 1, 'h62, 0, 0);
    cyc(1, 'h63, 1, 'h64, 0, 0);
    chk("pre_rst_occupancy", bus.occupancy, 4);
    bus.rel_valid_1 = 1'b0;
    bus.rel_valid_2 = 1'b0;
    bus.fl_ready    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rel_ready", bus.rel_ready, 1'b1);
    chk("async_fl_push", bus.fl_push, 1'b0);
    chk("async_fl_push_2", bus.fl_push_2, 1'b0);
    chk("async_occupancy", bus.occupancy, 0);
    chk("async_drain_ack", bus.drain_ack, 1'b0);
    #1 rst_n = 1'b1;
    bus.fl_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    cyc(1, 'h25, 1, 'h26, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
